// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, round limit and GF(2^8) helpers (S-box, Rcon).
package aes_pkg;
  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_key_t;
  typedef enum logic {IDLE, EMIT} keyexp_state_t;

  localparam int AES_NUM_ROUNDS = 10;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse is a^254 (maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] count);
    case (count)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/g_func_key_expansion.sv
// AES key-schedule g() word function: RotWord, SubWord, then Rcon XOR into the top byte.
module g_func_key_expansion
  import aes_pkg::*;
(
  input  aes_word_t   inputWord,
  input  logic [3:0]  count,
  output aes_word_t   outputWord
);
  aes_word_t rot_word;
  aes_word_t sub_word;

  assign rot_word = {inputWord[23:0], inputWord[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sub
      assign sub_word[gi*8 +: 8] = sbox(rot_word[gi*8 +: 8]);
    end
  endgenerate

  assign outputWord = sub_word ^ {rcon(count), 24'h0};
endmodule

// File: rtl/aes_key_expansion_engine.sv
// Sequential AES-128 key schedule streaming round keys 0..NUM_ROUNDS over valid/ready.
// Optional AES_KEY_STORE_EN adds a readable store of every emitted round key.
module aes_key_expansion_engine
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     cipher_key,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [127:0]     round_key,
  output logic [IDX_W-1:0] round_idx,
  output logic             done
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [127:0]     rd_key
`endif
);
  keyexp_state_t    state_q, state_d;
  aes_key_t         key_q, key_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  aes_word_t        g_word, n0, n1, n2, n3;
  logic             rk_hs, start_acc, last_idx;

  g_func_key_expansion u_g (
    .inputWord  (key_q[31:0]),
    .count      (idx_q[3:0]),
    .outputWord (g_word)
  );

  assign n0 = key_q[127:96] ^ g_word;
  assign n1 = key_q[95:64]  ^ n0;
  assign n2 = key_q[63:32]  ^ n1;
  assign n3 = key_q[31:0]   ^ n2;

  assign start_acc = (state_q == IDLE) && start;
  assign rk_hs     = (state_q == EMIT) && rk_ready;
  assign last_idx  = (idx_q == IDX_W'(NUM_ROUNDS));

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          key_d   = cipher_key;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_hs) begin
          if (last_idx) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = {n0, n1, n2, n3};
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign rk_valid  = (state_q == EMIT);
  assign round_key = key_q;
  assign round_idx = idx_q;
  assign done      = done_q;

`ifdef AES_KEY_STORE_EN
  aes_key_t store_q [NUM_ROUNDS+1];
  aes_key_t store_d [NUM_ROUNDS+1];
  aes_key_t rd_key_q, rd_key_d;

  // Out-of-range read indices match no entry and fall through to zero.
  always_comb begin
    rd_key_d = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      store_d[i] = store_q[i];
      if (start_acc) store_d[i] = '0;
      else if (rk_hs && (idx_q == IDX_W'(i))) store_d[i] = key_q;
      if (rd_idx == IDX_W'(i)) rd_key_d = store_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) store_q[i] <= '0;
      rd_key_q <= '0;
    end else begin
      for (int i = 0; i <= NUM_ROUNDS; i++) store_q[i] <= store_d[i];
      rd_key_q <= rd_key_d;
    end
  end

  assign rd_key = rd_key_q;
`endif
endmodule

// File: tb/tb_aes_key_expansion_engine.sv
// Scoreboard bench for aes_key_expansion_engine: FIPS-197 vectors, stalls, ignored starts, reset abort, random keys.
module tb_aes_key_expansion_engine;
  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready, busy, rk_valid, done;
  logic [127:0] cipher_key, round_key;
  logic [3:0]   round_idx;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [7:0] sbox_t [256];

  always #5 clk = ~clk;

  aes_key_expansion_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cipher_key (cipher_key),
    .busy       (busy),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .round_key  (round_key),
    .round_idx  (round_idx),
    .done       (done)
`ifdef AES_KEY_STORE_EN
    ,
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from exp/log tables over generator 3, then the affine map bit by bit.
  task automatic build_sbox();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] e, inv, s;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = e;
      lg[e] = i;
      e = e ^ xt(e);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ ((8'h63 >> b) & 8'h01) != 0;
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox_t[r[31:24]], sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]};
  endfunction

  // FIPS-197 word-array key expansion; published vectors replace rounds 1 and 10 for the FIPS key.
  task automatic push_expected(input logic [127:0] k, input bit fips);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    exp_t        e;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_rot(t) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) begin
      e.idx = r[3:0];
      e.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      if (fips && r == 1)  e.key = FIPS_RK1;
      if (fips && r == 10) e.key = FIPS_RK10;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: pops on every handshake, checks stall stability and the done pulse.
  initial begin : monitor
    logic         pending_done, prev_stall;
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;
    exp_t         e;
    pending_done = 1'b0;
    prev_stall   = 1'b0;
    prev_key     = '0;
    prev_idx     = '0;
    forever begin
      @(negedge clk);
      if (pending_done || done) check("done_pulse", done, pending_done);
      pending_done = 1'b0;
      if (prev_stall) begin
        check("stall_key", round_key, prev_key);
        check("stall_idx", round_idx, prev_idx);
      end
      prev_stall = 1'b0;
      if (rst) continue;
      if (rk_valid && rk_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key: got idx %0d key %h, required none", round_idx, round_key);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("round_key[%0d]", e.idx), round_key, e.key);
          check("round_idx", round_idx, e.idx);
          if (e.idx == 4'd10) pending_done = 1'b1;
        end
      end else if (rk_valid) begin
        prev_stall = 1'b1;
        prev_key   = round_key;
        prev_idx   = round_idx;
      end
    end
  end

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called at posedge+1; returns at posedge+1 once done is visible (or after reset abort).
  task automatic run(input logic [127:0] k, input bit fips, input int ready_pct,
                     input int stall_idx, input int bogus_idx, input int rst_idx);
    int cycles, stall_cnt;
    bit stalled, bogus_done;
    stall_cnt = 0;
    stalled = 0;
    bogus_done = 0;
    push_expected(k, fips);
    cipher_key = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cipher_key = rand_key();
    check("key0_latency", {rk_valid, round_idx}, {1'b1, 4'd0});
    cycles = 0;
    while (!done) begin
      if (cycles >= 300) begin
        checks++;
        errors++;
        $display("FAIL timeout: got no done after %0d cycles, required done", cycles);
        start = 1'b0;
        return;
      end
      if (rst_idx >= 0 && rk_valid && round_idx == rst_idx[3:0]) begin
        rst = 1'b1;
        start = 1'b1;
        rk_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        exp_q.delete();
        check("rst_busy", busy, 0);
        check("rst_valid", rk_valid, 0);
        check("rst_key", round_key, 0);
        check("rst_idx", round_idx, 0);
        repeat (3) @(posedge clk);
        #1;
        return;
      end
      if (stall_idx >= 0 && !stalled && rk_valid && round_idx == stall_idx[3:0]) begin
        stall_cnt = 3;
        stalled = 1;
      end
      if (stall_cnt > 0) begin
        rk_ready = 1'b0;
        stall_cnt--;
      end else begin
        rk_ready = ($urandom_range(99) < ready_pct);
      end
      start = 1'b0;
      if (bogus_idx >= 0 && !bogus_done && rk_valid && round_idx == bogus_idx[3:0]) begin
        start = 1'b1;
        cipher_key = rand_key();
        bogus_done = 1;
      end else if (ready_pct < 100 && $urandom_range(9) == 0) begin
        start = 1'b1;
        cipher_key = rand_key();
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    rk_ready = 1'b1;
    if (ready_pct == 100 && stall_idx < 0) check("done_latency", cycles, 11);
  endtask

  initial begin : stimulus
    int cycles;
    logic [127:0] k2;
    build_sbox();
    rst = 1'b1;
    start = 1'b0;
    rk_ready = 1'b1;
    cipher_key = '0;
`ifdef AES_KEY_STORE_EN
    rd_idx = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_valid", rk_valid, 0);
    check("reset_done", done, 0);
    check("reset_key", round_key, 0);
    check("reset_idx", round_idx, 0);

    run(FIPS_KEY, 1, 100, -1, -1, -1);
`ifdef AES_KEY_STORE_EN
    rd_idx = 4'd10; @(posedge clk); #1; check("store_rd10", rd_key, FIPS_RK10);
    rd_idx = 4'd0;  @(posedge clk); #1; check("store_rd0", rd_key, FIPS_KEY);
    rd_idx = 4'd12; @(posedge clk); #1; check("store_rd12", rd_key, 0);
`endif
    @(posedge clk); #1;
    run(FIPS_KEY, 1, 100, 4, -1, -1);
    run(FIPS_KEY, 1, 100, -1, 5, -1);
    run(FIPS_KEY, 1, 100, -1, -1, 7);
    run(FIPS_KEY, 1, 100, -1, -1, -1);

    // start held through the done cycle launches a second expansion immediately
    k2 = rand_key();
    push_expected(FIPS_KEY, 1);
    push_expected(k2, 0);
    cipher_key = FIPS_KEY;
    start = 1'b1;
    @(posedge clk); #1;
    cipher_key = k2;
    cycles = 0;
    while (!done && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("hold_done_seen", done, 1);
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_restart", {rk_valid, round_idx}, {1'b1, 4'd0});
    cycles = 0;
    while (!done && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("hold_second_done", done, 1);

    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      run(rand_key(), 0, 50 + 10 * n, (n % 2 == 0) ? int'($urandom_range(10)) : -1, -1, -1);
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
